rrf_commit_ctrl: RTL and testbench

- In-order commit controller paired with the RRF entry allocator: tracks dispatched and finished RRF entries and retires up to 2 per cycle.
- Drives commit count (`com_inst_num_o`) back to the allocator for free-count replenishment.
- Drives ARF write-enable/tag pairs for architectural update.
- Sits at the COM stage, downstream of DP (allocation) and EX writeback.

---
 rtl/rrf_commit_ctrl.sv | 148 ++++++++++++++
 tb/tb_rrf_commit_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_commit_ctrl.sv
// rrf_commit_ctrl: in-order commit controller for the rename register file.
// Tracks dispatched/finished RRF entries and retires up to two per cycle,
// reporting the commit count back to the allocator and driving ARF updates.
// Optional feature macro: RRF_COMMIT_FLUSH_EN (adds flush_i).
module rrf_commit_ctrl #(
    parameter int RRF_NUM = 64,
    parameter int RRF_SEL = 6,
    parameter int ARF_SEL = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
`ifdef RRF_COMMIT_FLUSH_EN
    input  logic               flush_i,
`endif
    input  logic               dp_en_i,
    input  logic [RRF_SEL-1:0] dp_rrftag_i,
    input  logic               dp_dst_en_i,
    input  logic [ARF_SEL-1:0] dp_arf_dst_i,
    input  logic               wb1_en_i,
    input  logic [RRF_SEL-1:0] wb1_rrftag_i,
    input  logic               wb2_en_i,
    input  logic [RRF_SEL-1:0] wb2_rrftag_i,
    input  logic               stall_com_i,
    output logic [1:0]         com_inst_num_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic               arfwe1_o,
    output logic [ARF_SEL-1:0] dstarf1_o,
    output logic [RRF_SEL-1:0] com_rrftag1_o,
    output logic               arfwe2_o,
    output logic [ARF_SEL-1:0] dstarf2_o,
    output logic [RRF_SEL-1:0] com_rrftag2_o,
    output logic [RRF_SEL:0]   occupied_o,
    output logic               empty_o
);

    localparam logic [RRF_SEL:0] OCC_MAX = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_NUM-1:0] valid_q, valid_d;
    logic [RRF_NUM-1:0] finished_q, finished_d;
    logic [RRF_NUM-1:0] dst_en_q, dst_en_d;
    logic [ARF_SEL-1:0] arf_dst_q [RRF_NUM];
    logic [ARF_SEL-1:0] arf_dst_d [RRF_NUM];
    logic [RRF_SEL-1:0] comptr_q, comptr_d;
    logic [RRF_SEL:0]   occupied_q, occupied_d;

    logic [RRF_SEL-1:0] head1, head2;
    logic               flush_w;
    logic               c1, c2;
    logic [1:0]         com_num;
    logic               dp_accept;

`ifdef RRF_COMMIT_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // Commit decision from registered state; the reset cycle never commits.
    always_comb begin
        head1     = comptr_q;
        head2     = comptr_q + RRF_SEL'(1);
        c1        = !reset_i && !stall_com_i && !flush_w
                    && valid_q[head1] && finished_q[head1];
        c2        = c1 && valid_q[head2] && finished_q[head2];
        com_num   = {1'b0, c1} + {1'b0, c2};
        dp_accept = dp_en_i && (!valid_q[dp_rrftag_i] || flush_w);
    end

    assign com_inst_num_o = com_num;
    assign comptr_o       = comptr_q;
    assign arfwe1_o       = c1 && dst_en_q[head1];
    assign arfwe2_o       = c2 && dst_en_q[head2];
    assign dstarf1_o      = arf_dst_q[head1];
    assign dstarf2_o      = arf_dst_q[head2];
    assign com_rrftag1_o  = head1;
    assign com_rrftag2_o  = head2;
    assign occupied_o     = occupied_q;
    assign empty_o        = (occupied_q == '0);

    // Next state: writeback, then commit retirement, flush, then dispatch capture.
    always_comb begin
        valid_d    = valid_q;
        finished_d = finished_q;
        dst_en_d   = dst_en_q;
        arf_dst_d  = arf_dst_q;
        comptr_d   = comptr_q + {{(RRF_SEL-2){1'b0}}, com_num};
        occupied_d = occupied_q + {{RRF_SEL{1'b0}}, dp_accept}
                     - {{(RRF_SEL-1){1'b0}}, com_num};

        if (wb1_en_i && valid_q[wb1_rrftag_i]) finished_d[wb1_rrftag_i] = 1'b1;
        if (wb2_en_i && valid_q[wb2_rrftag_i]) finished_d[wb2_rrftag_i] = 1'b1;

        if (c1) begin
            valid_d[head1]    = 1'b0;
            finished_d[head1] = 1'b0;
        end
        if (c2) begin
            valid_d[head2]    = 1'b0;
            finished_d[head2] = 1'b0;
        end

        if (flush_w) begin
            valid_d    = '0;
            finished_d = '0;
            comptr_d   = dp_en_i ? dp_rrftag_i : comptr_q;
            occupied_d = {{RRF_SEL{1'b0}}, dp_accept};
        end

        if (dp_accept) begin
            valid_d[dp_rrftag_i]    = 1'b1;
            finished_d[dp_rrftag_i] = 1'b0;
            dst_en_d[dp_rrftag_i]   = dp_dst_en_i;
            arf_dst_d[dp_rrftag_i]  = dp_arf_dst_i;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q    <= '0;
            finished_q <= '0;
            comptr_q   <= '0;
            occupied_q <= '0;
        end else begin
            valid_q    <= valid_d;
            finished_q <= finished_d;
            comptr_q   <= comptr_d;
            occupied_q <= occupied_d;
        end
    end

    // Per-entry payload; only meaningful while the entry is valid, so no reset.
    always_ff @(posedge clk_i) begin
        dst_en_q  <= dst_en_d;
        arf_dst_q <= arf_dst_d;
    end

    // Protocol checks: allocator must never hand out a live tag or overfill.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(dp_en_i && !flush_w && valid_q[dp_rrftag_i]));
            assert (!(dp_en_i && ((c1 && dp_rrftag_i == head1) ||
                                  (c2 && dp_rrftag_i == head2))));
            assert (occupied_q <= OCC_MAX);
        end
    end

endmodule

// File: tb/tb_rrf_commit_ctrl.sv
// Directed self-checking bench for rrf_commit_ctrl.
// Define RRF_COMMIT_FLUSH_EN to also exercise the flush feature.
module tb_rrf_commit_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       flush_i;
    logic       dp_en_i;
    logic [5:0] dp_rrftag_i;
    logic       dp_dst_en_i;
    logic [4:0] dp_arf_dst_i;
    logic       wb1_en_i;
    logic [5:0] wb1_rrftag_i;
    logic       wb2_en_i;
    logic [5:0] wb2_rrftag_i;
    logic       stall_com_i;
    logic [1:0] com_inst_num_o;
    logic [5:0] comptr_o;
    logic       arfwe1_o;
    logic [4:0] dstarf1_o;
    logic [5:0] com_rrftag1_o;
    logic       arfwe2_o;
    logic [4:0] dstarf2_o;
    logic [5:0] com_rrftag2_o;
    logic [6:0] occupied_o;
    logic       empty_o;

    int checks = 0;
    int failures = 0;

    rrf_commit_ctrl dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
`ifdef RRF_COMMIT_FLUSH_EN
        .flush_i(flush_i),
`endif
        .dp_en_i(dp_en_i),
        .dp_rrftag_i(dp_rrftag_i),
        .dp_dst_en_i(dp_dst_en_i),
        .dp_arf_dst_i(dp_arf_dst_i),
        .wb1_en_i(wb1_en_i),
        .wb1_rrftag_i(wb1_rrftag_i),
        .wb2_en_i(wb2_en_i),
        .wb2_rrftag_i(wb2_rrftag_i),
        .stall_com_i(stall_com_i),
        .com_inst_num_o(com_inst_num_o),
        .comptr_o(comptr_o),
        .arfwe1_o(arfwe1_o),
        .dstarf1_o(dstarf1_o),
        .com_rrftag1_o(com_rrftag1_o),
        .arfwe2_o(arfwe2_o),
        .dstarf2_o(dstarf2_o),
        .com_rrftag2_o(com_rrftag2_o),
        .occupied_o(occupied_o),
        .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle's inputs just after the edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic dp, input int tag, input logic dst,
                                 input int arf, input logic w1, input int t1,
                                 input logic w2, input int t2, input logic stall);
        dp_en_i      = dp;
        dp_rrftag_i  = tag[5:0];
        dp_dst_en_i  = dst;
        dp_arf_dst_i = arf[4:0];
        wb1_en_i     = w1;
        wb1_rrftag_i = t1[5:0];
        wb2_en_i     = w2;
        wb2_rrftag_i = t2[5:0];
        stall_com_i  = stall;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        flush_i = 1'b0;
        idle();
        tick();
        reset_i = 1'b0;
        idle();
    endtask

    initial begin
        reset_i = 1'b1;
        flush_i = 1'b0;
        idle();
        tick();
        tick();
        reset_i = 1'b0;
        idle();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_com", com_inst_num_o, 0);
            checkOutput("idle_comptr", comptr_o, 0);
            checkOutput("idle_empty", empty_o, 1);
            checkOutput("idle_occ", occupied_o, 0);
            tick();
        end

        // Two dispatches, out-of-order finish, dual commit
        applyStimulus(1'b1, 0, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 1, 1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 0, 1'b0);
        checkOutput("ooo_no_commit_a", com_inst_num_o, 0);
        checkOutput("ooo_occ", occupied_o, 2);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
        checkOutput("ooo_no_bypass", com_inst_num_o, 0);
        tick();
        idle();
        checkOutput("ooo_com", com_inst_num_o, 2);
        checkOutput("ooo_we1", arfwe1_o, 1);
        checkOutput("ooo_we2", arfwe2_o, 1);
        checkOutput("ooo_dst1", dstarf1_o, 3);
        checkOutput("ooo_dst2", dstarf2_o, 7);
        checkOutput("ooo_tag1", com_rrftag1_o, 0);
        checkOutput("ooo_tag2", com_rrftag2_o, 1);
        tick();
        checkOutput("ooo_comptr", comptr_o, 2);
        checkOutput("ooo_empty", empty_o, 1);

        // Stall holds commits; dual-port writeback to one tag is idempotent
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i, 1'b1, 10 + i, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b1, 1, 1'b1); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b1, 2, 1'b1); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b1, 3, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
            checkOutput("stall_com", com_inst_num_o, 0);
            checkOutput("stall_we1", arfwe1_o, 0);
            checkOutput("stall_occ", occupied_o, 4);
            tick();
        end
        idle();
        checkOutput("rel_com_a", com_inst_num_o, 2);
        checkOutput("rel_dst1_a", dstarf1_o, 10);
        tick();
        checkOutput("rel_occ_a", occupied_o, 2);
        checkOutput("rel_com_b", com_inst_num_o, 2);
        checkOutput("rel_dst2_b", dstarf2_o, 13);
        tick();
        checkOutput("rel_occ_b", occupied_o, 0);
        checkOutput("rel_comptr", comptr_o, 4);

        // Fill all entries, single commit, then full with both heads finished
        doReset();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, i, 1'b1, i % 32, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
        end
        idle();
        checkOutput("full_occ", occupied_o, 64);
        checkOutput("full_empty", empty_o, 0);
        checkOutput("full_com", com_inst_num_o, 0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0); tick();
        idle();
        checkOutput("full_com1", com_inst_num_o, 1);
        checkOutput("full_we1", arfwe1_o, 1);
        checkOutput("full_we2", arfwe2_o, 0);
        tick();
        checkOutput("full_comptr1", comptr_o, 1);
        checkOutput("full_occ63", occupied_o, 63);
        applyStimulus(1'b1, 0, 1'b1, 5, 1'b1, 1, 1'b1, 2, 1'b0); tick();
        idle();
        checkOutput("full2_occ", occupied_o, 64);
        checkOutput("full2_com", com_inst_num_o, 2);
        checkOutput("full2_dst2", dstarf2_o, 2);
        tick();
        checkOutput("full2_occ62", occupied_o, 62);
        checkOutput("full2_comptr", comptr_o, 3);

        // Walk head to 62 then commit across the wrap
        doReset();
        for (int i = 0; i < 62; i++) begin
            applyStimulus(1'b1, i, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0); tick();
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, i, 1'b0, 0, 1'b0); tick();
        end
        idle();
        tick();
        checkOutput("wrap_comptr62", comptr_o, 62);
        checkOutput("wrap_occ0", occupied_o, 0);
        applyStimulus(1'b1, 62, 1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 63, 1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 0, 1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 62, 1'b1, 63, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
        checkOutput("wrap_com2", com_inst_num_o, 2);
        checkOutput("wrap_tag2", com_rrftag2_o, 63);
        checkOutput("wrap_dst2", dstarf2_o, 2);
        tick();
        idle();
        checkOutput("wrap_comptr0", comptr_o, 0);
        checkOutput("wrap_com1", com_inst_num_o, 1);
        checkOutput("wrap_dst1", dstarf1_o, 4);
        tick();
        checkOutput("wrap_comptr1", comptr_o, 1);
        checkOutput("wrap_empty", empty_o, 1);

        // No destination register: commits without ARF write
        doReset();
        applyStimulus(1'b1, 0, 1'b0, 9, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0); tick();
        idle();
        checkOutput("nodst_com", com_inst_num_o, 1);
        checkOutput("nodst_we1", arfwe1_o, 0);
        checkOutput("nodst_dst1", dstarf1_o, 9);
        tick();

        // Reset arriving while the head is ready to commit
        applyStimulus(1'b1, 1, 1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 0, 1'b0); tick();
        reset_i = 1'b1;
        idle();
        checkOutput("rst_mid_com", com_inst_num_o, 0);
        checkOutput("rst_mid_we1", arfwe1_o, 0);
        tick();
        reset_i = 1'b0;
        idle();
        checkOutput("rst_mid_occ", occupied_o, 0);
        checkOutput("rst_mid_comptr", comptr_o, 0);
        checkOutput("rst_mid_empty", empty_o, 1);

`ifdef RRF_COMMIT_FLUSH_EN
        // Flush with five entries outstanding
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i, 1'b1, i, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0); tick();
        flush_i = 1'b1;
        idle();
        checkOutput("flush_com", com_inst_num_o, 0);
        checkOutput("flush_we1", arfwe1_o, 0);
        tick();
        flush_i = 1'b0;
        idle();
        checkOutput("flush_occ", occupied_o, 0);
        checkOutput("flush_empty", empty_o, 1);
        checkOutput("flush_comptr", comptr_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
